// File: rtl/pulse_train_gen_if.sv
// Config, trigger/stop and pulse/busy/done bundle for pulse_train_gen.
// Latency: none, this is plain wiring.
// Backpressure: none; the generator always accepts config writes and drops triggers while busy.
interface pulse_train_gen_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int CH_W     = 2
) ();

  // Config write port: one channel per strobe
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [CNT_W-1:0]    cfg_width;
  logic [CNT_W-1:0]    cfg_period;
  logic                cfg_mode;

  // Per-channel control
  logic [CHANNELS-1:0] trigger;
  logic [CHANNELS-1:0] stop;

  // Per-channel registered status
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;

  // Stimulus side: drives config and control, observes outputs
  modport master (
    output cfg_we, cfg_ch, cfg_width, cfg_period, cfg_mode,
    output trigger, stop,
    input  pulse, busy, done
  );

  // Generator side
  modport slave (
    input  cfg_we, cfg_ch, cfg_width, cfg_period, cfg_mode,
    input  trigger, stop,
    output pulse, busy, done
  );

endinterface

// File: rtl/pulse_train_gen.sv
// Multi-channel one-shot / periodic pulse generator with programmable high time and period.
// Latency: trigger sampled at edge N gives pulse/busy high from edge N+1; stop at S clears them at S+1.
// Backpressure: none; a trigger while busy is dropped, config writes are always accepted.
module pulse_train_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int CH_W     = 2
) (
  input  logic          clk,
  input  logic          reset,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // One channel's programmable settings; used both for the config and the active copy
  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic             mode;   // 0 = one-shot, 1 = periodic
  } cfg_t;

  localparam cfg_t CFG_RST = '{width: CNT_W'(1), period: CNT_W'(2), mode: 1'b0};

  // Incoming config word, shared by all channels
  cfg_t cfg_in;
  assign cfg_in.width  = bus.cfg_width;
  assign cfg_in.period = bus.cfg_period;
  assign cfg_in.mode   = bus.cfg_mode;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    cfg_t             cfg_q;       // last written settings
    cfg_t             act_q;       // settings governing the current period
    cfg_t             act_d;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_evt_q;  // one-shot just finished; feeds the done register
    logic             done_evt_d;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic             cfg_hit;
    logic             trig;
    logic             stp;
    logic [CNT_W-1:0] low_cnt;

    // Channel selects beyond CHANNELS match no generate index, so they are dropped here
    assign cfg_hit = bus.cfg_we && (int'(bus.cfg_ch) == i);
    assign trig    = bus.trigger[i];
    assign stp     = bus.stop[i];

    // LOW phase reload value: P-W-1 when P > W, otherwise a single low cycle
    assign low_cnt = (act_q.period > act_q.width)
                   ? (act_q.period - act_q.width - CNT_W'(1))
                   : '0;

    // Config register: writes land immediately but only reach the active set at a trigger or period boundary
    always_ff @(posedge clk) begin
      if (reset) begin
        cfg_q <= CFG_RST;
      end else if (cfg_hit) begin
        cfg_q <= cfg_in;
      end
    end

    // Next-state, counter and active-set update
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      act_d      = act_q;
      done_evt_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          // stop beats a simultaneous trigger; a zero width is not a pulse
          if (trig && !stp && (cfg_q.width != '0)) begin
            state_d = HIGH;
            act_d   = cfg_q;
            cnt_d   = cfg_q.width - CNT_W'(1);
          end
        end
        HIGH: begin
          if (stp) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            if (act_q.mode) begin
              state_d = LOW;
              cnt_d   = low_cnt;
            end else begin
              state_d    = IDLE;
              done_evt_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        LOW: begin
          if (stp) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            // Period boundary: pick up any new config. A width rewritten to zero ends the train.
            if (cfg_q.width != '0) begin
              state_d = HIGH;
              act_d   = cfg_q;
              cnt_d   = cfg_q.width - CNT_W'(1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // FSM state, counter and active-set registers
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        act_q      <= CFG_RST;
        done_evt_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        act_q      <= act_d;
        done_evt_q <= done_evt_d;
      end
    end

    // Output registers: decoded from the current state so nothing reaches the pins combinationally
    always_ff @(posedge clk) begin
      if (reset) begin
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        pulse_q <= (state_q == HIGH);
        busy_q  <= (state_q != IDLE);
        done_q  <= done_evt_q;
      end
    end

    assign bus.pulse[i] = pulse_q;
    assign bus.busy[i]  = busy_q;
    assign bus.done[i]  = done_q;

  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed scoreboard bench for pulse_train_gen: expected pulse/busy/done per cycle are queued with the stimulus.
// Latency: expectations are indexed from the trigger edge (k=0 is the edge that samples the trigger).
// Backpressure: not applicable; every cycle pops exactly one expectation.
module tb_pulse_train_gen;

  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pulse_train_gen_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  pulse_train_gen #(.CHANNELS(CHANNELS), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [CHANNELS-1:0] p;
    logic [CHANNELS-1:0] b;
    logic [CHANNELS-1:0] d;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t one_ch(int ch, logic p, logic b, logic d);
    obs_t o;
    o = '0;
    o.p[ch] = p;
    o.b[ch] = b;
    o.d[ch] = d;
    return o;
  endfunction

  function automatic obs_t all_ch(logic [CHANNELS-1:0] p, logic [CHANNELS-1:0] b, logic [CHANNELS-1:0] d);
    obs_t o;
    o.p = p;
    o.b = b;
    o.d = d;
    return o;
  endfunction

  task automatic push_idle(int n);
    repeat (n) exp_q.push_back('0);
  endtask

  // One-shot of width w: high for k=1..w, done (busy low) at k=w+1
  task automatic push_oneshot(int ch, int w);
    for (int k = 1; k <= w; k++) exp_q.push_back(one_ch(ch, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(one_ch(ch, 1'b0, 1'b0, 1'b1));
  endtask

  // Periodic train: rising edges max(P, W+1) apart, high time W
  task automatic push_periodic(int ch, int w, int p, int k0, int k1);
    int t;
    t = (p > w) ? p : w + 1;
    for (int k = k0; k <= k1; k++)
      exp_q.push_back(one_ch(ch, logic'(((k - 1) % t) < w), 1'b1, 1'b0));
  endtask

  // Advance one clock and compare outputs #1 after the edge against the head of the scoreboard
  task automatic tick(string tag);
    obs_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard got empty queue exp at least one entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (bus.pulse === e.p) else begin
        errors++;
        $error("FAIL %s pulse got %b exp %b", tag, bus.pulse, e.p);
      end
      checks++;
      assert (bus.busy === e.b) else begin
        errors++;
        $error("FAIL %s busy got %b exp %b", tag, bus.busy, e.b);
      end
      checks++;
      assert (bus.done === e.d) else begin
        errors++;
        $error("FAIL %s done got %b exp %b", tag, bus.done, e.d);
      end
    end
  endtask

  task automatic set_cfg(int ch, int w, int p, logic mode);
    bus.cfg_we     = 1'b1;
    bus.cfg_ch     = CH_W'(ch);
    bus.cfg_width  = CNT_W'(w);
    bus.cfg_period = CNT_W'(p);
    bus.cfg_mode   = mode;
  endtask

  // Config write while every channel is idle
  task automatic write_cfg(int ch, int w, int p, logic mode);
    set_cfg(ch, w, p, mode);
    push_idle(1);
    tick("cfg_write");
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_width  = '0;
    bus.cfg_period = '0;
    bus.cfg_mode   = 1'b0;
    bus.trigger    = '0;
    bus.stop       = '0;

    // Reset state
    repeat (2) @(posedge clk);
    push_idle(1);
    tick("reset");
    reset = 1'b0;
    push_idle(2);
    repeat (2) tick("post_reset");

    // Default config on ch0: one-cycle pulse, then done, then idle
    bus.trigger[0] = 1'b1;
    push_idle(1);
    push_oneshot(0, 1);
    push_idle(1);
    tick("dflt_trig");
    bus.trigger = '0;
    repeat (3) tick("dflt_oneshot");

    // ch1: W=3 P=5 periodic, stop after 12 cycles
    write_cfg(1, 3, 5, 1'b1);
    bus.trigger[1] = 1'b1;
    push_idle(1);
    push_periodic(1, 3, 5, 1, 13);
    tick("ch1_trig");
    bus.trigger = '0;
    repeat (12) tick("ch1_train");
    bus.stop[1] = 1'b1;
    tick("ch1_stop_edge");
    bus.stop = '0;
    push_idle(4);
    repeat (4) tick("ch1_stopped");

    // ch2: W=4 P=2 gives 4 high / 1 low; rewrite to W=2 P=6 as it enters LOW
    write_cfg(2, 4, 2, 1'b1);
    bus.trigger[2] = 1'b1;
    push_idle(1);
    push_periodic(2, 4, 2, 1, 10);
    push_periodic(2, 2, 6, 1, 13);
    tick("ch2_trig");
    bus.trigger = '0;
    repeat (8) tick("ch2_w4p2");
    set_cfg(2, 2, 6, 1'b1);
    tick("ch2_rewrite");
    bus.cfg_we = 1'b0;
    repeat (13) tick("ch2_w2p6");
    bus.stop[2] = 1'b1;
    tick("ch2_stop_edge");
    bus.stop = '0;
    push_idle(3);
    repeat (3) tick("ch2_stopped");

    // ch3: W=5 one-shot, retrigger during HIGH ignored, retrigger on the done edge accepted
    write_cfg(3, 5, 9, 1'b0);
    bus.trigger[3] = 1'b1;
    push_idle(1);
    push_oneshot(3, 5);
    push_oneshot(3, 5);
    push_idle(1);
    tick("ch3_trig");
    bus.trigger = '0;
    tick("ch3_high");
    bus.trigger[3] = 1'b1;
    tick("ch3_retrig_busy");
    bus.trigger = '0;
    repeat (3) tick("ch3_high");
    bus.trigger[3] = 1'b1;
    tick("ch3_done_retrig");
    bus.trigger = '0;
    repeat (7) tick("ch3_second");

    // ch3: stop and trigger together while idle
    bus.stop[3]    = 1'b1;
    bus.trigger[3] = 1'b1;
    push_idle(4);
    tick("ch3_stop_trig");
    bus.stop    = '0;
    bus.trigger = '0;
    repeat (3) tick("ch3_stop_trig_idle");

    // W=0 trigger on ch0 is ignored
    write_cfg(0, 0, 4, 1'b0);
    bus.trigger[0] = 1'b1;
    push_idle(4);
    tick("w0_trig");
    bus.trigger = '0;
    repeat (3) tick("w0_idle");

    // W=255 P=255 periodic on ch0: 255 high / 1 low
    write_cfg(0, 255, 255, 1'b1);
    bus.trigger[0] = 1'b1;
    push_idle(1);
    push_periodic(0, 255, 255, 1, 258);
    tick("w255_trig");
    bus.trigger = '0;
    repeat (257) tick("w255_train");
    bus.stop[0] = 1'b1;
    tick("w255_stop_edge");
    bus.stop = '0;
    push_idle(2);
    repeat (2) tick("w255_stopped");

    // All channels together, then reset mid-pulse with trigger and cfg_we also asserted
    for (int c = 0; c < CHANNELS; c++) write_cfg(c, 6, 8, 1'b0);
    bus.trigger = '1;
    push_idle(1);
    exp_q.push_back(all_ch('1, '1, '0));
    exp_q.push_back(all_ch('1, '1, '0));
    push_idle(1);
    tick("all_trig");
    bus.trigger = '0;
    repeat (2) tick("all_high");
    reset       = 1'b1;
    bus.trigger = '1;
    set_cfg(0, 7, 9, 1'b1);
    tick("mid_reset");
    reset       = 1'b0;
    bus.trigger = '0;
    bus.cfg_we  = 1'b0;
    push_idle(2);
    repeat (2) tick("after_reset");

    // Config back to defaults: every channel gives a 1-cycle one-shot
    bus.trigger = '1;
    push_idle(1);
    exp_q.push_back(all_ch('1, '1, '0));
    exp_q.push_back(all_ch('0, '0, '1));
    push_idle(1);
    tick("dflt_all_trig");
    bus.trigger = '0;
    repeat (3) tick("dflt_all");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover_expectations got %0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Multi-channel, parametrised pulse generator driven by a single clock. Each channel produces either a one-shot pulse or a periodic pulse train with a programmable high time and period, counted in `clk` cycles. It is the synthesisable successor to the fixed-width posedge pulser used in the clock/waveform testbenches. It sits beside the `clock` module as the standard stimulus and strobe source for timing labs.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent channels; must be ≥ 2.
- `CNT_W`, default 8: width of the width/period counters and config fields.
- `CH_W`, default 2: channel-select width; must equal clog2(`CHANNELS`).

Ports:
- `clk`  in  1  sole clock; all logic updates on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `cfg_we`  in  1  write strobe for channel `cfg_ch`'s configuration.
- `cfg_ch`  in  `CH_W`  channel selected by a config write. Values ≥ `CHANNELS` are ignored.
- `cfg_width`  in  `CNT_W`  high time W, in cycles.
- `cfg_period`  in  `CNT_W`  period P, in cycles (periodic mode only).
- `cfg_mode`  in  1  0 = one-shot, 1 = periodic.
- `trigger`  in  `CHANNELS`  per-channel start request.
- `stop`  in  `CHANNELS`  per-channel abort.
- `pulse`  out  `CHANNELS`  registered pulse outputs.
- `busy`  out  `CHANNELS`  high while the channel is not IDLE.
- `done`  out  `CHANNELS`  one-cycle strobe when a one-shot pulse completes.

## Operation
- Each channel has a config register set (W, P, mode) and an active set.
- Per-channel FSM states:
  - IDLE: `pulse`=0, `busy`=0.
  - HIGH: `pulse`=1, `busy`=1.
  - LOW: `pulse`=0, `busy`=1.
- IDLE → HIGH on `trigger` when config W ≠ 0.
  - The active set is loaded from the config values present before the edge.
  - The down-counter is loaded with W−1.
- Trigger with W = 0 is ignored: the channel stays IDLE and no `done` is produced.
- HIGH, counter = 0:
  - One-shot: go to IDLE and assert `done` for one cycle.
  - Periodic: go to LOW; counter loaded with L−1, where L = P−W if P > W, else L = 1.
- LOW, counter = 0: go to HIGH. The active set is reloaded from config at this point, so config changes take effect at the next period boundary.
- `stop` in HIGH or LOW: go to IDLE; no `done`.
- `stop` in IDLE: no effect.
- `stop` and `trigger` on the same channel in the same cycle: `stop` wins and the channel stays or returns to IDLE.
- `trigger` while `busy`: ignored, with no retrigger and no counter restart.
- Config writes never disturb an active HIGH or LOW count.
- All arithmetic is unsigned `CNT_W`-bit. P−W is computed only when P > W, so there is no wrap.
- Channels are fully independent. Simultaneous triggers on several channels all start in the same cycle.
- `reset` values:
  - `pulse`, `busy` and `done` all 0.
  - All FSMs IDLE, counters 0.
  - Config per channel: W=1, P=2, mode=0.
- `reset` mid-pulse forces all of the above on the next edge, overriding `trigger`, `stop` and `cfg_we`.

## Timing
- `trigger` sampled at edge N:
  - `pulse` is high for cycles N+1 … N+W, exactly W cycles.
  - `busy` rises at N+1.
- One-shot:
  - `pulse` falls at edge N+W+1.
  - `done`=1 for cycle N+W+1 only.
  - `busy` falls at N+W+1.
  - A new `trigger` is accepted at edge N+W+1.
- Periodic: rising edges of `pulse` are max(P, W+1) cycles apart; the high time is always W.
- `stop` sampled at edge S: `pulse` and `busy` are 0 from cycle S+1.
- Config write at edge C is visible to a trigger sampled at edge C+1 or later.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Reset, then `trigger[0]` for 1 cycle with defaults → `pulse[0]` high 1 cycle, then `done[0]` 1 cycle later, then `busy[0]` 0.
- ch1: W=3, P=5, periodic; trigger → `pulse[1]` repeats 3 high / 2 low. Assert `stop[1]` after 12 cycles → `pulse[1]` low next cycle, `done[1]` never asserted.
- ch2: W=4, P=2, periodic → 4 high / 1 low. Rewrite to W=2, P=6 mid-LOW → next HIGH is 2 cycles, then 4 low.
- ch3: W=5 one-shot. Re-trigger during HIGH → ignored, still exactly 5 high. Assert `stop` and `trigger` together while IDLE → no pulse.
- W=0 trigger → no pulse, no `done`. W=255, P=255 periodic → 255 high / 1 low.
- All channels triggered together, then `reset` mid-pulse → every output 0 next cycle and config back to W=1, P=2, one-shot.
